// File: rtl/ext_pipe_if.sv
// ext_pipe_if: request/response bundle for the ext_pipe extension unit.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// exactly when valid && ready are both high at that edge. The producer
// holds its payload stable while valid is high and ready is low.
//
// Signals
//   in_valid/in_ready   request handshake (producer -> ext_pipe)
//   in_op               mode select
//   in_imm              immediate source
//   in_data, in_off     memory read word and byte offset for load modes
//   in_tag              destination-register tag, passed through
//   flush               synchronous squash of all buffered entries
//   out_valid/out_ready result handshake (ext_pipe -> consumer)
//   out_data/out_tag    extended result and its tag
//   out_err             illegal request marker (out_data is 0)
//
// Modports
//   master  the side that drives requests and consumes results
//   slave   the ext_pipe unit itself
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OFF_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_imm, in_data, in_off, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_data, in_off, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with a 2-entry skid
// buffer on its output.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    ext_pipe_if.slave: request side (in_*), flush, result side (out_*)
//
// Each accepted request is extended combinationally and written into the
// buffer at the accepting edge, together with its tag and an error flag.
// in_ready depends only on the stored count, so there is no combinational
// path from out_ready to in_ready.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OFF_W  = 2
) (
  input  logic       clk,
  input  logic       reset,
  ext_pipe_if.slave  bus
);

  localparam logic [2:0] OP_ZEXT = 3'b000;
  localparam logic [2:0] OP_SEXT = 3'b001;
  localparam logic [2:0] OP_LUI  = 3'b010;
  localparam logic [2:0] OP_LB   = 3'b011;
  localparam logic [2:0] OP_LBU  = 3'b100;
  localparam logic [2:0] OP_LH   = 3'b101;
  localparam logic [2:0] OP_LHU  = 3'b110;

  // ---------------- extension datapath ----------------
  logic [15:0]       half_v;
  logic [7:0]        byte_v;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  // Shift the addressed byte down to bit 0; the low 16 bits then hold the
  // selected byte or halfword.
  assign half_v = 16'(bus.in_data >> {bus.in_off, 3'b000});
  assign byte_v = half_v[7:0];

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (bus.in_op)
      OP_ZEXT: res_data = DATA_W'(bus.in_imm);
      OP_SEXT: res_data = DATA_W'($signed(bus.in_imm));
      OP_LUI:  res_data = DATA_W'(bus.in_imm) << (DATA_W - IMM_W);
      OP_LB:   res_data = DATA_W'($signed(byte_v));
      OP_LBU:  res_data = DATA_W'(byte_v);
      OP_LH: begin
        if (bus.in_off[0]) res_err = 1'b1;
        else               res_data = DATA_W'($signed(half_v));
      end
      OP_LHU: begin
        if (bus.in_off[0]) res_err = 1'b1;
        else               res_data = DATA_W'(half_v);
      end
      default: res_err = 1'b1;
    endcase
  end

  // ---------------- 2-entry skid buffer ----------------
  logic [DATA_W-1:0] mem_data [2];
  logic [TAG_W-1:0]  mem_tag  [2];
  logic              mem_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic in_ready_i;
  logic out_valid_i;
  logic push;
  logic pop;

  assign in_ready_i  = (count != 2'd2);
  assign out_valid_i = (count != 2'd0);
  assign push        = bus.in_valid && in_ready_i;
  assign pop         = out_valid_i && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else if (bus.flush) begin
      // Squash wins over any accept or pop in the same cycle; stale entry
      // contents are harmless because out_valid is low afterwards.
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= res_data;
        mem_tag[wr_ptr]  <= bus.in_tag;
        mem_err[wr_ptr]  <= res_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_tag   = mem_tag[rd_ptr];
  assign bus.out_err   = mem_err[rd_ptr];

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: bench for ext_pipe (32-bit instance with a queue-based
// reference, plus a 64-bit instance with directed constants).
module tb_ext_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ext_pipe_if #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .OFF_W(2)) b ();
  ext_pipe_if #(.IMM_W(16), .DATA_W(64), .TAG_W(5), .OFF_W(3)) b64 ();

  ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .OFF_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  ext_pipe #(.IMM_W(16), .DATA_W(64), .TAG_W(5), .OFF_W(3)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (b64.slave)
  );

  // ---------------- scoreboard ----------------
  // entry layout: [37:6] data, [5:1] tag, [0] err
  logic [37:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: {err, data} computed from the mode rules with plain arithmetic.
  function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [15:0] imm,
                                          input logic [31:0] data, input logic [1:0] off);
    longint unsigned iv, scale, bv, hv, r;
    logic err;
    iv    = imm;
    scale = longint'(1) << (8 * off);
    bv    = (longint'(data) / scale) % 256;
    hv    = (longint'(data) / scale) % 65536;
    r     = 0;
    err   = 1'b0;
    case (op)
      3'd0: r = iv;
      3'd1: r = (iv >= 32768) ? iv + 64'hFFFF_0000 : iv;
      3'd2: r = iv * 65536;
      3'd3: r = (bv >= 128) ? bv + 64'hFFFF_FF00 : bv;
      3'd4: r = bv;
      3'd5: if (off % 2 == 1) err = 1'b1; else r = (hv >= 32768) ? hv + 64'hFFFF_0000 : hv;
      3'd6: if (off % 2 == 1) err = 1'b1; else r = hv;
      default: err = 1'b1;
    endcase
    return {err, 32'(r)};
  endfunction

  // Called at a negedge with this cycle's inputs applied: checks occupancy,
  // scores any pop, records any accept, then advances to the next negedge.
  task automatic tick();
    logic [37:0] e;
    logic [32:0] r;
    check("occ_valid", b.out_valid, exp_q.size() != 0);
    check("occ_ready", b.in_ready, exp_q.size() < 2);
    if (b.flush) begin
      exp_q.delete();
    end else begin
      if (b.out_valid && b.out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", b.out_data, e[37:6]);
        check("sb_tag",  b.out_tag,  e[5:1]);
        check("sb_err",  b.out_err,  e[0]);
      end
      if (b.in_valid && b.in_ready) begin
        r = ref_ext(b.in_op, b.in_imm, b.in_data, b.in_off);
        exp_q.push_back({r[31:0], b.in_tag, r[32]});
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] data,
                           input logic [1:0] off, input logic [4:0] tag);
    b.in_valid = 1'b1;
    b.in_op    = op;
    b.in_imm   = imm;
    b.in_data  = data;
    b.in_off   = off;
    b.in_tag   = tag;
  endtask

  task automatic drive_rand(input logic [4:0] tag);
    drive_req(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 2'($urandom_range(0, 3)), tag);
  endtask

  // One request with an empty buffer and out_ready high; result must be
  // visible one edge later.
  task automatic directed(input string name, input logic [2:0] op, input logic [15:0] imm,
                          input logic [31:0] data, input logic [1:0] off, input logic [4:0] tag,
                          input logic [31:0] exp_data, input logic exp_err);
    b.out_ready = 1'b1;
    drive_req(op, imm, data, off, tag);
    tick();
    b.in_valid = 1'b0;
    check({name, "_valid"}, b.out_valid, 1);
    check({name, "_data"},  b.out_data,  exp_data);
    check({name, "_tag"},   b.out_tag,   tag);
    check({name, "_err"},   b.out_err,   exp_err);
    tick();
  endtask

  task automatic req64(input string name, input logic [2:0] op, input logic [15:0] imm,
                       input logic [63:0] data, input logic [2:0] off, input logic [63:0] exp_data,
                       input logic exp_err);
    b64.in_valid = 1'b1;
    b64.in_op    = op;
    b64.in_imm   = imm;
    b64.in_data  = data;
    b64.in_off   = off;
    b64.in_tag   = 5'd9;
    @(negedge clk);
    b64.in_valid = 1'b0;
    check({name, "_valid"}, b64.out_valid, 1);
    check({name, "_data"},  b64.out_data,  exp_data);
    check({name, "_err"},   b64.out_err,   exp_err);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    reset = 1'b0;
    b.in_valid = 1'b0; b.in_op = '0; b.in_imm = '0; b.in_data = '0;
    b.in_off = '0; b.in_tag = '0; b.flush = 1'b0; b.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_op = '0; b64.in_imm = '0; b64.in_data = '0;
    b64.in_off = '0; b64.in_tag = '0; b64.flush = 1'b0; b64.out_ready = 1'b1;

    #1;
    check("rst_valid", b.out_valid, 0);
    check("rst_ready", b.in_ready,  1);
    check("rst_data",  b.out_data,  0);
    check("rst_tag",   b.out_tag,   0);
    check("rst_err",   b.out_err,   0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Immediate and load modes
    directed("sext", 3'b001, 16'h8001, 32'h0, 2'd0, 5'd3, 32'hFFFF8001, 1'b0);
    directed("zext", 3'b000, 16'h8001, 32'h0, 2'd0, 5'd4, 32'h00008001, 1'b0);
    directed("lui",  3'b010, 16'h8001, 32'h0, 2'd0, 5'd5, 32'h80010000, 1'b0);
    directed("lb",   3'b011, 16'h0, 32'h80F17F02, 2'd2, 5'd6,  32'hFFFFFFF1, 1'b0);
    directed("lbu",  3'b100, 16'h0, 32'h80F17F02, 2'd2, 5'd7,  32'h000000F1, 1'b0);
    directed("lh",   3'b101, 16'h0, 32'h80F17F02, 2'd2, 5'd8,  32'hFFFF80F1, 1'b0);
    directed("lhu",  3'b110, 16'h0, 32'h80F17F02, 2'd0, 5'd9,  32'h00007F02, 1'b0);
    directed("lh_mis", 3'b101, 16'h0, 32'h80F17F02, 2'd1, 5'd10, 32'h0, 1'b1);
    directed("rsvd", 3'b111, 16'h1234, 32'hFFFFFFFF, 2'd0, 5'd11, 32'h0, 1'b1);

    // Backpressure: tags 1,2,3 back-to-back with out_ready low
    b.out_ready = 1'b0;
    drive_rand(5'd1); tick();
    drive_rand(5'd2); tick();
    drive_rand(5'd3);
    check("bp_full_ready", b.in_ready, 0);
    tick();
    check("bp_hold_ready", b.in_ready, 0);
    tick();
    b.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = b.in_ready;
      tick();
    end
    if (!acc) check("bp_accept", b.in_ready, 1);
    b.in_valid = 1'b0;
    tick(); tick();

    // Count 1 with simultaneous accept and pop for 10 cycles
    b.out_ready = 1'b0;
    drive_rand(5'd20); tick();
    b.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(5'(i));
      check("c1_ready", b.in_ready,  1);
      check("c1_valid", b.out_valid, 1);
      tick();
    end
    b.in_valid = 1'b0;
    tick(); tick();

    // Flush with two entries buffered and a request offered
    b.out_ready = 1'b0;
    drive_rand(5'd12); tick();
    drive_rand(5'd13); tick();
    drive_rand(5'd14);
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    check("flush2_valid", b.out_valid, 0);
    check("flush2_ready", b.in_ready,  1);
    tick();

    // Flush at count 1 discards a same-cycle accept and pop
    drive_rand(5'd15); tick();
    drive_rand(5'd16);
    b.out_ready = 1'b1;
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    check("flush1_valid", b.out_valid, 0);
    tick();

    // Asynchronous reset while full
    b.out_ready = 1'b0;
    drive_req(3'b000, 16'hBEEF, 32'h0, 2'd0, 5'd17); tick();
    drive_req(3'b000, 16'hCAFE, 32'h0, 2'd0, 5'd18); tick();
    b.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", b.out_valid, 0);
    check("arst_data",  b.out_data,  0);
    check("arst_tag",   b.out_tag,   0);
    check("arst_err",   b.out_err,   0);
    check("arst_ready", b.in_ready,  1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive_rand(5'($urandom));
      b.in_valid  = ($urandom_range(0, 3) != 0);
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    tick(); tick(); tick();
    check("drain_empty", exp_q.size(), 0);

    // 64-bit datapath
    req64("w64_lh",  3'b101, 16'h0, 64'hABCD_0000_0000_0000, 3'd6, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
    req64("w64_lbu", 3'b100, 16'h0, 64'hABCD_0000_0000_0000, 3'd7, 64'h0000_0000_0000_00AB, 1'b0);
    req64("w64_lui", 3'b010, 16'h8001, 64'h0, 3'd0, 64'h8001_0000_0000_0000, 1'b0);
    req64("w64_sext", 3'b001, 16'h8001, 64'h0, 3'd0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    req64("w64_mis", 3'b110, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 64'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender. Intended for the pipelined datapath (P5/P6).
- Performs immediate extension (zero, sign, load-upper) and load-data sub-word extension (lb/lbu/lh/lhu) on a DATA_W datapath.
- Carries a register tag alongside each result.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush for branch/exception squash.

Parameters:
- IMM_W, 16, immediate width. Must satisfy IMM_W <= DATA_W.
- DATA_W, 32, datapath width. Must be a multiple of 16 and >= 16.
- TAG_W, 5, width of the destination-register tag carried with each result.
- OFF_W, 2, byte-offset width. Equals log2(DATA_W/8).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  3  mode select (see Behaviour).
- in_imm  input  IMM_W  immediate source.
- in_data  input  DATA_W  memory read word, for load modes.
- in_off  input  OFF_W  byte offset within in_data.
- in_tag  input  TAG_W  destination tag, passed through unchanged.
- flush  input  1  synchronous squash of all buffered entries.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  DATA_W  extended result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  request was illegal; out_data is 0.

Behaviour:
- Modes (in_op):
  - 000 zero-extend in_imm.
  - 001 sign-extend in_imm from bit IMM_W-1.
  - 010 load-upper: in_imm placed in bits DATA_W-1 : DATA_W-IMM_W, low bits 0.
  - 011 lb: byte at in_off, sign-extended.
  - 100 lbu: byte at in_off, zero-extended.
  - 101 lh: halfword at in_off, sign-extended.
  - 110 lhu: halfword at in_off, zero-extended.
  - 111 reserved.
- Byte selection: byte k = in_data[8k+7:8k], where k = in_off. Halfword selection: in_data[8k+15:8k].
- Errors: out_err = 1 and result 0 for op 111, and for op 101/110 with in_off[0] = 1 (misaligned). Errors still occupy a buffer entry and handshake normally.
- Storage: 2 entries {data, tag, err}, write pointer, read pointer, count 0..2.
- Handshakes:
  - in_ready = (count != 2), a combinational function of count only.
  - Accept when in_valid && in_ready. Result is computed combinationally and written at the edge.
  - out_valid = (count != 0).
  - out_data, out_tag and out_err present the entry at the read pointer. Pop when out_valid && out_ready.
- Latency: a request accepted at edge N is visible on the outputs after edge N when the buffer was empty. Throughput is one per cycle with out_ready held high.
- Simultaneous events:
  - Accept and pop in the same cycle (count 1): count stays 1, order is preserved.
  - Count 2: no accept is possible. A pop leaves count 1.
  - Count 0: pop is impossible because out_valid = 0.
- Pointers wrap modulo 2.
- Outputs are held stable while out_valid && !out_ready.
- flush = 1 at an edge:
  - count, write pointer and read pointer are cleared.
  - Any accept or pop in that same cycle is discarded.
  - out_valid = 0 after the edge.
  - in_ready is not gated by flush.
- Reset (reset = 0, asynchronous): count 0, pointers 0, all entry fields 0. Consequently out_valid 0, in_ready 1, out_data 0, out_tag 0, out_err 0. Reset in mid-transfer drops all entries. Deassertion is synchronised externally.
- No internal combinational path from out_ready to in_ready.

Test Plan:
- Reset, then op 001, imm 16'h8001, tag 3 with out_ready = 1 -> next cycle out_data 32'hFFFF8001, out_tag 3, out_err 0. Op 000 with the same imm -> 32'h00008001. Op 010 -> 32'h80010000.
- Loads with in_data 32'h80F17F02:
  - op 011, off 2 -> 32'hFFFFFFF1.
  - op 100, off 2 -> 32'h000000F1.
  - op 101, off 2 -> 32'hFFFF80F1.
  - op 110, off 0 -> 32'h00007F02.
  - op 101, off 1 -> out_err 1, out_data 0.
- Backpressure: out_ready = 0, issue tags 1, 2, 3 back-to-back -> in_ready low after 2 accepts, tag 3 held by the source. Raise out_ready -> tags emerge 1, 2, 3 in order with no loss or duplication.
- With count 1, accept and pop in the same cycle for 10 cycles -> count stays 1 and all 10 results appear in order.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid 0, in_ready 1. The flushed-cycle request is not delivered.
- Assert reset low asynchronously between edges while count = 2 -> out_valid drops immediately, out_data = 0, in_ready = 1.
- Parametrised run with DATA_W = 64, IMM_W = 16, OFF_W = 3, lh at off 6 of 64'hABCD_0000_0000_0000 -> 64'hFFFF_FFFF_FFFF_ABCD.
